// File: rtl/wasca_pio_edge_capture.sv
// wasca_pio_edge_capture
// Input conditioning for the 4 cartridge PIO lines: two-flop synchronizer,
// optional per-line glitch filter, programmable edge capture into sticky
// RW1C flags, and a maskable registered level interrupt on an Avalon-MM
// slave with zero wait states.
// Build option: define WASCA_PIO_EDGE_FILTER_EN to instantiate the glitch
// filter (FILTER_CYCLES stable cycles before the conditioned level moves).
// Without it the conditioned level is the synchronizer output, one cycle later.
module wasca_pio_edge_capture #(
    parameter int FILTER_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  pins_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [1:0] ADDR_LEVEL     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_MODE = 2'd3;

    // The filter counter is 8 bits wide, so the stability length must fit.
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter_cycles
        $error("FILTER_CYCLES must be in 1..255");
    end

    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  lvl;
    logic [3:0]  lvl_d;
    logic [3:0]  irq_mask;
    logic [3:0]  edge_cap;
    logic [7:0]  edge_mode;
    logic        wr_en;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  cap_set;
    logic [3:0]  cap_clr;
    logic [31:0] rd_mux;
    logic        unused_writedata_hi;

    assign wr_en               = chipselect & ~write_n;
    assign unused_writedata_hi = ^writedata[31:8];

    // Two-flop synchronizer for the asynchronous pin levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pins_in;
            s2 <= s1;
        end
    end

`ifdef WASCA_PIO_EDGE_FILTER_EN
    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

    logic [7:0] flt_cnt [4];

    // Glitch filter: lvl follows s2 only after it has differed for FILTER_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl <= '0;
            for (int i = 0; i < 4; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == lvl[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CNT_LAST) begin
                    lvl[i]     <= s2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    // Unfiltered: conditioned level is the synchronizer output, registered once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl <= '0;
        end else begin
            lvl <= s2;
        end
    end
`endif

    assign rise    = lvl & ~lvl_d;
    assign fall    = ~lvl & lvl_d;
    assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? writedata[3:0] : 4'd0;

    // Per-line edge qualification against the 2-bit mode field
    always_comb begin
        cap_set = '0;
        for (int i = 0; i < 4; i++) begin
            cap_set[i] = (edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]);
        end
    end

    // Control registers; a capture set overrides a same-cycle W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_d     <= '0;
            irq_mask  <= '0;
            edge_mode <= '0;
            edge_cap  <= '0;
        end else begin
            lvl_d    <= lvl;
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
            if (wr_en && address == ADDR_IRQ_MASK) begin
                irq_mask <= writedata[3:0];
            end
            if (wr_en && address == ADDR_EDGE_MODE) begin
                edge_mode <= writedata[7:0];
            end
        end
    end

    // Read mux; reads have no side effects
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_LEVEL:     rd_mux = {28'd0, lvl};
            ADDR_IRQ_MASK:  rd_mux = {28'd0, irq_mask};
            ADDR_EDGE_CAP:  rd_mux = {28'd0, edge_cap};
            ADDR_EDGE_MODE: rd_mux = {24'd0, edge_mode};
            default:        rd_mux = '0;
        endcase
    end

    // Registered read data (loaded every cycle) and level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: tb/tb_wasca_pio_edge_capture.sv
// Testbench for wasca_pio_edge_capture: directed timing scenarios plus a
// randomized run checked against a window-based reference model.
`timescale 1ns/1ps
module tb_wasca_pio_edge_capture;

    localparam int FC = 16;
`ifdef WASCA_PIO_EDGE_FILTER_EN
    localparam int FE = FC;
`else
    localparam int FE = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  pins_in = 4'h0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (values after the most recent clock edge)
    logic [3:0]  m_lvl, m_lvl_old, m_mask, m_cap;
    logic [7:0]  m_mode;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [3:0]  hist[$];

    wasca_pio_edge_capture #(.FILTER_CYCLES(FC)) dut (
        .clk(clk), .reset_n(reset_n), .pins_in(pins_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_lvl = 0; m_lvl_old = 0; m_mask = 0; m_cap = 0; m_mode = 0;
        m_rd = 0; m_irq = 0;
        hist.delete();
        for (int i = 0; i < FE + 4; i++) hist.push_back(4'h0);
    endtask

    // Advance one clock edge and update the model from the inputs seen at it.
    // The conditioned level of a line flips once the FE most recent samples
    // old enough to have crossed the synchronizer all disagree with it.
    task automatic tick();
        logic [3:0]  p, set, clr, nlvl, h;
        logic [1:0]  a, md;
        logic [31:0] wd;
        logic        wr, rv, r, f, st;
        p = pins_in; wr = chipselect && !write_n; a = address; wd = writedata; rv = reset_n;
        @(posedge clk);
        if (!rv) begin
            m_reset();
        end else begin
            case (a)
                2'd0: m_rd = {28'd0, m_lvl};
                2'd1: m_rd = {28'd0, m_mask};
                2'd2: m_rd = {28'd0, m_cap};
                default: m_rd = {24'd0, m_mode};
            endcase
            m_irq = (m_cap & m_mask) != 4'd0;
            set = 4'd0;
            for (int i = 0; i < 4; i++) begin
                md = m_mode[2*i +: 2];
                r = m_lvl[i] && !m_lvl_old[i];
                f = !m_lvl[i] && m_lvl_old[i];
                if ((md == 2'b01 && r) || (md == 2'b10 && f) || (md == 2'b11 && (r || f)))
                    set[i] = 1'b1;
            end
            clr = (wr && a == 2'd2) ? wd[3:0] : 4'd0;
            m_cap = (m_cap & ~clr) | set;
            if (wr && a == 2'd1) m_mask = wd[3:0];
            if (wr && a == 2'd3) m_mode = wd[7:0];
            hist.push_back(p);
            if (hist.size() > FE + 8) void'(hist.pop_front());
            nlvl = m_lvl;
            for (int i = 0; i < 4; i++) begin
                st = 1'b1;
                for (int j = 0; j < FE; j++) begin
                    h = hist[hist.size() - 3 - j];
                    if (h[i] == m_lvl[i]) st = 1'b0;
                end
                if (st) nlvl[i] = !m_lvl[i];
            end
            m_lvl_old = m_lvl;
            m_lvl = nlvl;
        end
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pins_in = 4'hF; address = 2'd0;
        wait_cycles(3);
        n_cmp++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: readdata=%h irq=%b, expected 0 and 0", readdata, irq);
        end
        reset_n = 1'b1;
        wait_cycles(50);
        tick();
        n_cmp++;
        if (readdata !== 32'hF) begin
            n_bad++;
            $display("FAIL reset_level: LEVEL=%h expected %h", readdata, 32'hF);
        end
        address = 2'd2;
        tick();
        n_cmp++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cap: EDGE_CAP=%h irq=%b, expected 0 and 0", readdata, irq);
        end
    endtask

    task automatic test_rise();
        pins_in = 4'h0;
        wait_cycles(FE + 6);
        do_write(2'd2, 32'hF);
        do_write(2'd3, 32'h01);
        do_write(2'd1, 32'h1);
        address = 2'd0;
        pins_in[0] = 1'b1;
        for (int t = 1; t <= FE + 5; t++) begin
            tick();
            n_cmp++;
            if (readdata[0] !== (t >= FE + 3) || irq !== (t >= FE + 4)) begin
                n_bad++;
                $display("FAIL rise_timing t=%0d: level=%b irq=%b, expected level=%b irq=%b",
                         t, readdata[0], irq, (t >= FE + 3), (t >= FE + 4));
            end
        end
        address = 2'd2;
        tick();
        n_cmp++;
        if (readdata !== 32'h1) begin
            n_bad++;
            $display("FAIL rise_cap: EDGE_CAP=%h expected %h", readdata, 32'h1);
        end
        address = 2'd2; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL w1c_irq_hold: irq=%b expected 1", irq);
        end
        tick();
        n_cmp++;
        if (irq !== 1'b0 || readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL w1c_irq_drop: irq=%b cap=%h, expected 0 and 0", irq, readdata);
        end
    endtask

    task automatic test_pulse();
        do_write(2'd1, 32'h0);
        do_write(2'd2, 32'hF);
`ifdef WASCA_PIO_EDGE_FILTER_EN
        do_write(2'd3, 32'h30);
        address = 2'd0;
        pins_in[2] = 1'b1;
        wait_cycles(FC - 1);
        pins_in[2] = 1'b0;
        for (int t = 0; t < FC + 8; t++) begin
            tick();
            n_cmp++;
            if (readdata[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL short_pulse_level t=%0d: level=%b expected 0", t, readdata[2]);
            end
        end
        address = 2'd2;
        tick();
        n_cmp++;
        if (readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL short_pulse_cap: EDGE_CAP=%h expected 0", readdata);
        end
        pins_in[2] = 1'b1;
        wait_cycles(FC);
        pins_in[2] = 1'b0;
        wait_cycles(FC + 10);
        n_cmp++;
        if (readdata !== 32'h4) begin
            n_bad++;
            $display("FAIL long_pulse_cap: EDGE_CAP=%h expected %h", readdata, 32'h4);
        end
`else
        do_write(2'd3, 32'h04);
        address = 2'd2;
        pins_in[1] = 1'b1;
        tick();
        pins_in[1] = 1'b0;
        wait_cycles(8);
        n_cmp++;
        if (readdata !== 32'h2) begin
            n_bad++;
            $display("FAIL one_cycle_pulse_cap: EDGE_CAP=%h expected %h", readdata, 32'h2);
        end
`endif
        do_write(2'd2, 32'hF);
    endtask

    task automatic test_set_wins();
        do_write(2'd1, 32'h0);
        do_write(2'd3, 32'h80);
        pins_in = 4'h8;
        wait_cycles(FE + 6);
        do_write(2'd2, 32'hF);
        address = 2'd2;
        pins_in[3] = 1'b0;
        tick();
        for (int t = 2; t <= FE + 3; t++) begin
            if (t == FE + 3) begin
                writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
            end
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;
        n_cmp++;
        if (readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL set_wins_before: EDGE_CAP=%h expected 0", readdata);
        end
        tick();
        n_cmp++;
        if (readdata !== 32'h8) begin
            n_bad++;
            $display("FAIL set_wins: EDGE_CAP=%h expected %h", readdata, 32'h8);
        end
        do_write(2'd2, 32'h8);
        address = 2'd2;
        tick();
        n_cmp++;
        if (readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL set_wins_clear: EDGE_CAP=%h expected 0", readdata);
        end
    endtask

    task automatic test_mask();
        pins_in = 4'h0;
        wait_cycles(FE + 6);
        do_write(2'd2, 32'hF);
        do_write(2'd3, 32'h14);
        do_write(2'd1, 32'h0);
        pins_in = 4'h6;
        wait_cycles(FE + 6);
        address = 2'd2;
        tick();
        n_cmp++;
        if (irq !== 1'b0 || readdata !== 32'h6) begin
            n_bad++;
            $display("FAIL mask_off: irq=%b cap=%h, expected 0 and 6", irq, readdata);
        end
        do_write(2'd1, 32'h4);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_edge_w: irq=%b expected 0", irq);
        end
        address = 2'd2;
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_on: irq=%b expected 1", irq);
        end
        tick();
        n_cmp++;
        if (readdata !== 32'h6 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL read_no_clear: cap=%h irq=%b, expected 6 and 1", readdata, irq);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                pins_in = 4'($urandom);
                hold = $urandom_range(1, 2 * FE + 3);
            end
            hold--;
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            address    = 2'($urandom);
            writedata  = $urandom;
            reset_n    = ($urandom_range(0, 699) != 0);
            tick();
            n_cmp++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_bad++;
                $display("FAIL random c=%0d: readdata=%h irq=%b, expected readdata=%h irq=%b",
                         c, readdata, irq, m_rd, m_irq);
            end
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_rise();
        test_pulse();
        test_set_wins();
        test_mask();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
